// File: rtl/mc_pkg.sv
// Shared constants, state encodings and decode payload for the multi-cycle MIPS control unit.
package mc_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OP_W-1:0] OP_R    = 6'h00;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI  = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW   = 6'h23;
  localparam logic [OP_W-1:0] OP_SW   = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OP_W-1:0] OP_J    = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL  = 6'h03;

  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_JR   = 6'h08;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DCD    = 4'd1,
    S_EXE    = 4'd2,
    S_ALUWB  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_JMP    = 4'd9,
    S_ERR    = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_JMP,
    CL_ILL
  } cls_e;

  localparam logic [SEL_W-1:0] NPC_PC4   = 2'b00;
  localparam logic [SEL_W-1:0] NPC_BEQ   = 2'b01;
  localparam logic [SEL_W-1:0] NPC_J     = 2'b10;
  localparam logic [SEL_W-1:0] NPC_JR    = 2'b11;

  localparam logic [SEL_W-1:0] REG_RT    = 2'b00;
  localparam logic [SEL_W-1:0] REG_RD    = 2'b01;
  localparam logic [SEL_W-1:0] REG_RA    = 2'b10;

  localparam logic [SEL_W-1:0] EXT_ZERO  = 2'b00;
  localparam logic [SEL_W-1:0] EXT_SIGN  = 2'b01;
  localparam logic [SEL_W-1:0] EXT_UPPER = 2'b10;

  localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALU_OR    = 2'b10;

  localparam logic [SEL_W-1:0] WD_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] WD_DM     = 2'b01;
  localparam logic [SEL_W-1:0] WD_PC4    = 2'b10;

  typedef struct packed {
    cls_e             cls;
    logic             is_jal;
    logic [SEL_W-1:0] npc_op;
    logic [SEL_W-1:0] regdst;
    logic [SEL_W-1:0] ext_op;
    logic             alusrc;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] wdsel;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Pure combinational decode of the latched instruction into a class and datapath selects.
module mc_decode
  import mc_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec
);

  logic [OP_W-1:0] opcode;
  logic [OP_W-1:0] funct;
  logic            unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  // Register/immediate fields are consumed by the datapath, not by control.
  assign unused_fields = ^instr[25:6];

  always_comb begin
    dec     = '0;
    dec.cls = CL_ILL;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADDU: begin
            dec.cls    = CL_ALU;
            dec.regdst = REG_RD;
            dec.alu_op = ALU_ADD;
          end
          FN_SUBU: begin
            dec.cls    = CL_ALU;
            dec.regdst = REG_RD;
            dec.alu_op = ALU_SUB;
          end
          FN_JR: begin
            dec.cls    = CL_JMP;
            dec.npc_op = NPC_JR;
          end
          default: dec.cls = CL_ILL;
        endcase
      end
      OP_ORI: begin
        dec.cls    = CL_ALU;
        dec.regdst = REG_RT;
        dec.alusrc = 1'b1;
        dec.ext_op = EXT_ZERO;
        dec.alu_op = ALU_OR;
      end
      // lui relies on rs=$0 so OR-ing the upper-extended immediate yields it directly.
      OP_LUI: begin
        dec.cls    = CL_ALU;
        dec.regdst = REG_RT;
        dec.alusrc = 1'b1;
        dec.ext_op = EXT_UPPER;
        dec.alu_op = ALU_OR;
      end
      OP_LW: begin
        dec.cls    = CL_LW;
        dec.regdst = REG_RT;
        dec.alusrc = 1'b1;
        dec.ext_op = EXT_SIGN;
        dec.alu_op = ALU_ADD;
        dec.wdsel  = WD_DM;
      end
      OP_SW: begin
        dec.cls    = CL_SW;
        dec.alusrc = 1'b1;
        dec.ext_op = EXT_SIGN;
        dec.alu_op = ALU_ADD;
      end
      OP_BEQ: begin
        dec.cls    = CL_BEQ;
        dec.npc_op = NPC_BEQ;
        dec.ext_op = EXT_SIGN;
        dec.alu_op = ALU_SUB;
      end
      OP_J: begin
        dec.cls    = CL_JMP;
        dec.npc_op = NPC_J;
      end
      OP_JAL: begin
        dec.cls    = CL_JMP;
        dec.is_jal = 1'b1;
        dec.npc_op = NPC_J;
        dec.regdst = REG_RA;
        dec.wdsel  = WD_PC4;
      end
      default: dec.cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and write-enable gating.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter bit ILLEGAL_TO_FETCH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 zero,
  output logic                 pcwr,
  output logic [SEL_W-1:0]     npc_op,
  output logic                 irwr,
  output logic                 gprwr,
  output logic [SEL_W-1:0]     regdst,
  output logic [SEL_W-1:0]     ext_op,
  output logic                 alusrc,
  output logic [SEL_W-1:0]     alu_op,
  output logic                 dmwr,
  output logic [SEL_W-1:0]     wdsel,
  output logic [STATE_W-1:0]   state,
  output logic                 err
);

  state_e state_q;
  state_e state_d;
  dec_t   dec;

  mc_decode u_decode (
    .instr (instr),
    .dec   (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DCD;
      S_DCD: begin
        case (dec.cls)
          CL_ALU:        state_d = S_EXE;
          CL_LW, CL_SW:  state_d = S_MEMADR;
          CL_BEQ:        state_d = S_BRANCH;
          CL_JMP:        state_d = S_JMP;
          default:       state_d = ILLEGAL_TO_FETCH ? S_FETCH : S_ERR;
        endcase
      end
      S_EXE:    state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_MEMADR: state_d = (dec.cls == CL_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JMP:    state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs; enables are killed while rst is high so nothing writes during reset.
  always_comb begin
    pcwr   = 1'b0;
    irwr   = 1'b0;
    gprwr  = 1'b0;
    dmwr   = 1'b0;
    err    = 1'b0;
    npc_op = dec.npc_op;
    regdst = dec.regdst;
    ext_op = dec.ext_op;
    alusrc = dec.alusrc;
    alu_op = dec.alu_op;
    wdsel  = dec.wdsel;
    case (state_q)
      S_FETCH: begin
        irwr   = 1'b1;
        pcwr   = 1'b1;
        npc_op = NPC_PC4;
      end
      S_ALUWB:  gprwr = 1'b1;
      S_MEMWB:  gprwr = 1'b1;
      S_MEMWR:  dmwr  = 1'b1;
      S_BRANCH: pcwr  = zero;
      S_JMP: begin
        pcwr  = 1'b1;
        gprwr = dec.is_jal;
      end
      S_ERR:    err   = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pcwr  = 1'b0;
      irwr  = 1'b0;
      gprwr = 1'b0;
      dmwr  = 1'b0;
      err   = 1'b0;
    end
  end

  assign state = STATE_W'(state_q);

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle MIPS control unit, directly downstream of the instruction register.
- Consumes the latched instruction and the ALU zero flag.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives every write enable and datapath select, including irwr back to the IR and pcwr to the PC.
- Supported set: addu, subu, jr, ori, lui, lw, sw, beq, j, jal.

Parameters:
- ILLEGAL_TO_FETCH, 1, unsupported instruction returns to FETCH after DCD (1) or traps in ERR (0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- instr  in  32  current instruction from the IR.
- zero  in  1  ALU equality flag.
- pcwr  out  1  PC write enable.
- npc_op  out  2  next-PC select: 00 PC+4, 01 beq target, 10 j/jal target, 11 jr (rs).
- irwr  out  1  IR write enable.
- gprwr  out  1  register-file write enable.
- regdst  out  2  destination register: 00 rt, 01 rd, 10 $31.
- ext_op  out  2  immediate extend: 00 zero, 01 sign, 10 upper (lui).
- alusrc  out  1  ALU B operand: 0 rt, 1 extended immediate.
- alu_op  out  2  ALU function: 00 add, 01 sub, 10 or.
- dmwr  out  1  data-memory write enable.
- wdsel  out  2  register write-data source: 00 ALU, 01 DM, 10 PC+4.
- state  out  4  current state (debug).
- err  out  1  high while in ERR.

Behaviour:
- Reset:
  - rst=1 forces state=FETCH(0) immediately.
  - While rst=1, pcwr, irwr, gprwr, dmwr are forced to 0 and err=0.
  - The first cycle after release is FETCH.
- Outputs are Moore-style, combinational from the registered state and instr.
  - Select fields (npc_op, regdst, ext_op, alusrc, alu_op, wdsel) are pure decodes of instr and are valid in every state.
  - Write enables are asserted only in the states listed below; otherwise 0.
- State encoding: FETCH 0, DCD 1, EXE 2, ALUWB 3, MEMADR 4, MEMRD 5, MEMWB 6, MEMWR 7, BRANCH 8, JMP 9, ERR 15. Unused codes go to FETCH.
- FETCH: irwr=1, pcwr=1, npc_op=00. Next: DCD.
- DCD: no enables. Next state by instruction:
  - addu/subu/ori/lui -> EXE
  - lw/sw -> MEMADR
  - beq -> BRANCH
  - j/jal/jr -> JMP
  - otherwise -> FETCH if ILLEGAL_TO_FETCH=1, else ERR.
- EXE -> ALUWB. ALUWB: gprwr=1, wdsel=00. Next: FETCH.
- MEMADR: lw -> MEMRD, sw -> MEMWR.
- MEMRD -> MEMWB. MEMWB: gprwr=1, wdsel=01. Next: FETCH.
- MEMWR: dmwr=1. Next: FETCH.
- BRANCH: pcwr=zero, npc_op=01. Next: FETCH.
- JMP: pcwr=1.
  - jal: gprwr=1, regdst=10, wdsel=10.
  - jr: npc_op=11, gprwr=0.
  - Next: FETCH.
- ERR: no enables, err=1. Held until rst.
- Decode field rules:
  - addu/subu: regdst=01, alusrc=0, alu_op=00/01.
  - ori: regdst=00, alusrc=1, ext_op=00, alu_op=10.
  - lui: regdst=00, alusrc=1, ext_op=10, alu_op=10 (OR with $0 rs assumed by encoding).
  - lw/sw: alusrc=1, ext_op=01, alu_op=00.
  - beq: alusrc=0, alu_op=01, ext_op=01.
- Cycle counts: ALU 4, lw 5, sw 4, beq 3, j/jal/jr 3.
- instr must be stable from DCD until return to FETCH; irwr is asserted only in FETCH, which guarantees this.
- Reset asserted in any state aborts the instruction. No partial writes occur after the reset edge.

Decomposition:
- Package mc_pkg holds:
  - opcode/funct constants: R 00, funct addu 21h, subu 23h, jr 08h; ori 0Dh, lui 0Fh, lw 23h, sw 2Bh, beq 04h, j 02h, jal 03h.
  - state encodings.
  - npc_op/regdst/ext_op/alu_op/wdsel encodings.
- One combinational sub-module, mc_decode: instr -> instruction class plus select fields.
- mc_ctrl keeps the state register, next-state logic and enable gating.

Test Plan:
1. Assert rst mid-MEMRD during lw 0x8C220004 -> state=0 and all enables 0 at once. First cycle after release: irwr=1, pcwr=1, npc_op=00.
2. addu 0x00221821 -> states 0,1,2,3,0. gprwr=1 only in ALUWB. regdst=01, alu_op=00, wdsel=00.
3. lw 0x8C220004 -> 5 cycles, gprwr in MEMWB with wdsel=01, ext_op=01. sw 0xAC220004 -> 4 cycles, dmwr=1 only in MEMWR, gprwr never.
4. beq 0x10220003 with zero=1 -> BRANCH pcwr=1, npc_op=01. Repeat with zero=0 -> pcwr=0. 3 cycles each.
5. jal 0x0C000010 -> JMP: pcwr=1, npc_op=10, gprwr=1, regdst=10, wdsel=10. jr 0x03E00008 -> npc_op=11, gprwr=0.
6. Illegal 0xFC000000:
   - ILLEGAL_TO_FETCH=1 -> back to FETCH after DCD, no writes.
   - =0 -> state 15, err=1 held 20 cycles until rst, all enables 0.
